spi_wb_bridge: RTL and testbench



---
 rtl/spi_wb_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_spi_wb_bridge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_bridge.sv
// SPI slave (mode 0, MSB first) to 8-bit Wishbone master bridge.
// One chip-select frame carries a single-byte write (cmd, addr, data)
// or read (cmd, addr, dummy, data-out). SPI pins are oversampled in clk.
module spi_wb_bridge #(
   parameter int         TIMEOUT      = 32,
   parameter logic [7:0] TIMEOUT_DATA = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic [7:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   input  logic       wb_ack_i,
   output logic       busy_o,
   output logic       timeout_o
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WAIT_RD, DONE} state_t;

   localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

   state_t     state, state_next;
   logic [2:0] sclk_sync;
   logic [2:0] cs_sync;
   logic [1:0] mosi_sync;
   logic [2:0] bit_cnt;
   logic [1:0] byte_idx;
   logic [7:0] rx_shift;
   logic [7:0] rx_byte;
   logic [7:0] tx_shift;
   logic [7:0] adr_lat;
   logic       we_lat;
   logic       rd_pend;
   logic [5:0] tmo_cnt;
   logic       sclk_rise, sclk_fall, cs_high, cs_fall, byte_done;
   logic       latch_we, latch_adr, latch_dat, req;
   logic       tmo_hit, rd_done, miso_en;
   logic [7:0] rd_value;

   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
   assign cs_high   = cs_sync[1];
   assign cs_fall   = cs_sync[2] & ~cs_sync[1];
   assign rx_byte   = {rx_shift[6:0], mosi_sync[1]};
   assign byte_done = sclk_rise && !cs_high && (bit_cnt == 3'd7);
   assign tmo_hit   = wb_cyc_o && !wb_ack_i && (tmo_cnt == TMO_LAST);
   assign rd_done   = wb_cyc_o && !wb_we_o && (wb_ack_i || tmo_hit);
   assign rd_value  = wb_ack_i ? wb_dat_i : TIMEOUT_DATA;
   assign miso_en   = (state == DONE) && !we_lat && (byte_idx == 2'd3);
   assign wb_stb_o  = wb_cyc_o;
   assign busy_o    = wb_cyc_o;

   // Two-flop synchronisers plus one delay stage for edge detection; cs idles high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= 3'b000;
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[1:0], spi_sclk};
         cs_sync   <= {cs_sync[1:0], spi_cs_n};
         mosi_sync <= {mosi_sync[0], spi_mosi};
      end
   end

   // Receive shifter with bit counter and saturating byte index, cleared while deselected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt  <= 3'd0;
         byte_idx <= 2'd0;
         rx_shift <= 8'd0;
      end else if (cs_high) begin
         bit_cnt  <= 3'd0;
         byte_idx <= 2'd0;
      end else if (sclk_rise) begin
         rx_shift <= rx_byte;
         bit_cnt  <= bit_cnt + 3'd1;
         if (bit_cnt == 3'd7 && byte_idx != 2'd3)
            byte_idx <= byte_idx + 2'd1;
      end
   end

   // Frame state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Frame sequencing; deselect always returns to IDLE
   always_comb begin
      state_next = state;
      if (cs_high)
         state_next = IDLE;
      else begin
         case (state)
            IDLE:    if (cs_fall)   state_next = CMD;
            CMD:     if (byte_done) state_next = ADDR;
            ADDR:    if (byte_done) state_next = we_lat ? DATA : WAIT_RD;
            DATA:    if (byte_done) state_next = DONE;
            WAIT_RD: if (byte_done) state_next = DONE;
            default: state_next = state;
         endcase
      end
   end

   // Latch strobes and bus request, issued in the clk a byte completes
   always_comb begin
      latch_we  = 1'b0;
      latch_adr = 1'b0;
      latch_dat = 1'b0;
      req       = 1'b0;
      if (byte_done) begin
         case (state)
            CMD:  latch_we = 1'b1;
            ADDR: begin
               latch_adr = 1'b1;
               req       = !we_lat;
            end
            DATA: begin
               latch_dat = 1'b1;
               req       = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Command direction and address held for the rest of the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_lat  <= 1'b0;
         adr_lat <= 8'd0;
      end else begin
         if (latch_we)  we_lat  <= rx_byte[7];
         if (latch_adr) adr_lat <= rx_byte;
      end
   end

   // Single-slot Wishbone engine with ack-or-timeout termination; ack beats timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_cyc_o  <= 1'b0;
         wb_adr_o  <= 8'd0;
         wb_dat_o  <= 8'd0;
         wb_we_o   <= 1'b0;
         tmo_cnt   <= 6'd0;
         timeout_o <= 1'b0;
      end else begin
         timeout_o <= 1'b0;
         if (wb_cyc_o) begin
            if (wb_ack_i)
               wb_cyc_o <= 1'b0;
            else if (tmo_hit) begin
               wb_cyc_o  <= 1'b0;
               timeout_o <= 1'b1;
            end else
               tmo_cnt <= tmo_cnt + 6'd1;
         end else if (req) begin
            wb_cyc_o <= 1'b1;
            tmo_cnt  <= 6'd0;
            wb_we_o  <= we_lat;
            wb_adr_o <= latch_adr ? rx_byte : adr_lat;
            if (latch_dat) wb_dat_o <= rx_byte;
         end
      end
   end

   // Read data capture into the transmit shifter and MISO drive on falling edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift <= 8'd0;
         spi_miso <= 1'b0;
         rd_pend  <= 1'b0;
      end else if (cs_high) begin
         tx_shift <= 8'd0;
         spi_miso <= 1'b0;
         rd_pend  <= 1'b0;
      end else begin
         if (req && !we_lat)
            rd_pend <= 1'b1;
         if (rd_done && rd_pend) begin
            tx_shift <= rd_value;
            rd_pend  <= 1'b0;
         end else if (sclk_fall && miso_en) begin
            spi_miso <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Self-checking bench for spi_wb_bridge: directed frames plus randomized
// frames against a frame-level reference model and a simple Wishbone slave.
module tb_spi_wb_bridge;

   localparam int TIMEOUT = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_sclk = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic [7:0] wb_adr_o, wb_dat_o;
   logic [7:0] wb_dat_i = 8'h00;
   logic       wb_cyc_o, wb_stb_o, wb_we_o;
   logic       wb_ack_i = 1'b0;
   logic       busy_o, timeout_o;

   int         errors = 0;
   int         checks = 0;

   int         ackDelay = 0;
   logic [7:0] slaveData = 8'h00;
   int         nCycles = 0, nTimeouts = 0, curHigh = 0, lastHigh = 0;
   int         trackErr = 0, unstableErr = 0;
   logic [7:0] logAdr = 8'h00, logDat = 8'h00;
   logic       logWe = 1'b0;

   spi_wb_bridge #(.TIMEOUT(TIMEOUT), .TIMEOUT_DATA(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   // Wishbone slave: acks after ackDelay clks of stb (0 = never), random data otherwise
   initial begin
      forever begin
         @(negedge clk);
         wb_ack_i = 1'b0;
         wb_dat_i = 8'($urandom);
         if (timeout_o) nTimeouts++;
         if (busy_o !== wb_cyc_o || wb_stb_o !== wb_cyc_o) trackErr++;
         if (wb_cyc_o) begin
            curHigh++;
            if (curHigh == 1) begin
               nCycles++;
               logAdr = wb_adr_o;
               logDat = wb_dat_o;
               logWe  = wb_we_o;
            end else if (wb_adr_o !== logAdr || wb_dat_o !== logDat || wb_we_o !== logWe)
               unstableErr++;
            if (curHigh == ackDelay) begin
               wb_ack_i = 1'b1;
               wb_dat_i = slaveData;
            end
         end else if (curHigh > 0) begin
            lastHigh = curHigh;
            curHigh  = 0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (wb_cyc_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (wb_cyc_o) checkOutput("bus idle wait", 1, 0);
      repeat (2) @(negedge clk);
      #1;
   endtask

   // Master side of one byte, mode 0: drive on low, sample MISO at rising edge
   task automatic spiByte(input logic [7:0] txByte, input int nBits, output logic [7:0] rxByte);
      rxByte = 8'h00;
      for (int i = 7; i >= 8 - nBits; i--) begin
         spi_mosi = txByte[i];
         #80 spi_sclk = 1'b1;
         rxByte = {rxByte[6:0], spi_miso};
         #80 spi_sclk = 1'b0;
      end
   endtask

   // One frame of nBytes bytes (or aborted after abortBits bits), checked against the model
   task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] adr, input logic [7:0] dat,
                                input int nBytes, input int abortBits, input int dly, input logic [7:0] rd);
      logic [7:0] tx [5];
      logic [7:0] rx;
      logic [7:0] expRd;
      logic       isWrite, replied;
      int         c0, t0, expCycles, expHigh;
      waitIdle();
      ackDelay  = dly;
      slaveData = rd;
      c0 = nCycles;
      t0 = nTimeouts;
      tx[0] = cmd; tx[1] = adr; tx[2] = dat; tx[3] = 8'($urandom); tx[4] = 8'($urandom);
      isWrite = cmd[7];
      replied = (dly >= 1) && (dly <= TIMEOUT);
      expRd   = replied ? rd : 8'hFF;
      expHigh = replied ? dly : TIMEOUT;
      if (abortBits > 0)
         expCycles = 0;
      else if (isWrite)
         expCycles = (nBytes >= 3) ? 1 : 0;
      else
         expCycles = (nBytes >= 2) ? 1 : 0;

      @(negedge clk);
      #2 spi_cs_n = 1'b0;
      #100;
      if (abortBits > 0) begin
         spiByte(cmd, 8, rx);
         checkOutput("miso abort cmd", rx, 0);
         spiByte(adr, abortBits - 8, rx);
      end else begin
         for (int b = 0; b < nBytes; b++) begin
            spiByte(tx[b], 8, rx);
            checkOutput($sformatf("miso byte%0d cmd=%0h", b, cmd), rx,
                        (!isWrite && b == 3) ? expRd : 8'h00);
         end
      end
      #100 spi_cs_n = 1'b1;
      #200;
      checkOutput("miso deselected", spi_miso, 0);
      waitIdle();

      checkOutput("cycle count", nCycles - c0, expCycles);
      if (expCycles == 1) begin
         checkOutput("wb adr", logAdr, adr);
         checkOutput("wb we", logWe, isWrite);
         if (isWrite) checkOutput("wb dat", logDat, dat);
         checkOutput("stb high clks", lastHigh, expHigh);
         checkOutput("timeout pulses", nTimeouts - t0, replied ? 0 : 1);
      end else
         checkOutput("timeout pulses idle", nTimeouts - t0, 0);
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] cmd;
      int         nb, dly;

      #23;
      checkOutput("reset outputs",
                  {spi_miso, wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o, timeout_o}, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      applyStimulus(8'h80, 8'h12, 8'h5A, 3, 0, 2, 8'h00);
      applyStimulus(8'h00, 8'h25, 8'h00, 4, 0, 3, 8'h3C);
      applyStimulus(8'h00, 8'h40, 8'h00, 4, 0, 0, 8'h00);
      applyStimulus(8'h80, 8'h77, 8'h00, 3, 10, 2, 8'h00);
      applyStimulus(8'h80, 8'h01, 8'hA5, 3, 0, 2, 8'h00);
      applyStimulus(8'h00, 8'h33, 8'h00, 4, 0, TIMEOUT, 8'h96);
      applyStimulus(8'h7F, 8'h0A, 8'h00, 5, 0, TIMEOUT + 1, 8'h11);

      // Asynchronous reset while a read to an unmapped address is outstanding
      waitIdle();
      ackDelay = 0;
      @(negedge clk);
      #2 spi_cs_n = 1'b0;
      #100;
      spiByte(8'h00, 8, rx);
      spiByte(8'h40, 8, rx);
      for (int i = 0; i < 20 && !wb_cyc_o; i++) @(negedge clk);
      checkOutput("cyc before reset", wb_cyc_o, 1);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async reset outputs",
                  {spi_miso, wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o, timeout_o}, 0);
      spi_cs_n = 1'b1;
      #50 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      applyStimulus(8'h80, 8'h2C, 8'hC3, 3, 0, 1, 8'h00);

      for (int k = 0; k < 20; k++) begin
         cmd = 8'($urandom);
         nb  = $urandom_range(2, 5);
         dly = $urandom_range(0, 40);
         applyStimulus(cmd, 8'($urandom), 8'($urandom), nb, 0, dly, 8'($urandom));
      end

      checkOutput("stb/busy track cyc", trackErr, 0);
      checkOutput("adr/dat/we stable", unstableErr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
